reg_file_arbiter: RTL

REG_FILE_ARBITER -- requirements
Module: reg_file_arbiter

---
 rtl/reg_file_arbiter_pkg.sv | 12 +
 rtl/reg_file_4.sv | 23 ++
 rtl/reg_file_arbiter.sv | 85 ++++++++
 3 files changed

// File: rtl/reg_file_arbiter_pkg.sv
// Shared state encoding and width default for the register-file arbiter.
package reg_file_arbiter_pkg;

    localparam int WIDTH_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/reg_file_4.sv
// Four-entry register file: synchronous write, combinational read.
module reg_file_4 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reg_write,
    input  logic [1:0]       address,
    input  logic [WIDTH-1:0] w_data,
    output logic [WIDTH-1:0] r_data
);

    logic [WIDTH-1:0] regs [4];

    // NOTE: storage is deliberately not reset; contents survive an arbiter reset.
    always_ff @(posedge clk) begin
        if (reg_write) begin
            regs[address] <= w_data;
        end
    end

    assign r_data = regs[address];

endmodule

// File: rtl/reg_file_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port register file.
// Each access takes IDLE -> SERVE -> DONE, so at most one access per three cycles.
module reg_file_arbiter
    import reg_file_arbiter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic             we0,
    input  logic             we1,
    input  logic [1:0]       addr0,
    input  logic [1:0]       addr1,
    input  logic [WIDTH-1:0] wdata0,
    input  logic [WIDTH-1:0] wdata1,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] rdata,
    output logic             busy,
    output logic [1:0]       rf_address,
    output logic [WIDTH-1:0] rf_w_data,
    output logic             rf_regWrite,
    input  logic [WIDTH-1:0] rf_r_data
);

    state_t           state;
    state_t           state_next;
    logic             prio;
    logic             grant;
    logic             sel;
    logic             lat_we;
    logic [1:0]       lat_addr;
    logic [WIDTH-1:0] lat_wdata;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        grant      = req1;
        if (req0 && req1) begin
            grant = prio;
        end
        unique case (state)
            IDLE:    if (req0 || req1) state_next = SERVE;
            SERVE:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            prio      <= 1'b0;
            sel       <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rdata     <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && (req0 || req1)) begin
                sel       <= grant;
                prio      <= ~grant;
                lat_we    <= grant ? we1 : we0;
                lat_addr  <= grant ? addr1 : addr0;
                lat_wdata <= grant ? wdata1 : wdata0;
            end
            if (state == SERVE && !lat_we) begin
                rdata <= rf_r_data;
            end
        end
    end

    // The latched request doubles as the register-file bus, so it holds between accesses.
    assign rf_address  = lat_addr;
    assign rf_w_data   = lat_wdata;
    assign rf_regWrite = (state == SERVE) && lat_we && !reset;
    assign busy        = (state != IDLE);
    assign done0       = (state == DONE) && !sel;
    assign done1       = (state == DONE) && sel;

endmodule
